// File: rtl/qs_fetch.sv
// qs_fetch: instruction-fetch sequencer feeding a fetch->decode register from qs_ucode_rom.
// Optional macro QS_FETCH_JMP_FOLD_EN: fold unconditional J into the PC update at fetch.
module qs_fetch #(
    parameter int PC_W     = 8,
    parameter int INST_W   = 16,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic [PC_W-1:0]   rom_ra,
    input  logic [INST_W-1:0] rom_rout,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [INST_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_pc,
    output logic              out_folded,
    input  logic              redirect_vld,
    input  logic [PC_W-1:0]   redirect_pc
);
    localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

    logic [PC_W-1:0]   pc_q, pc_d, opc_q, opc_d, nxt_pc;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              vld_q, vld_d, fold_q, fold_d;
    logic              cap, xfer, jmp;

    // Handshake qualifiers, unconditional-J predecode and sequential/folded next PC
    always_comb begin
        xfer = vld_q & out_rdy;
        cap  = fetch_en & ~redirect_vld & (~vld_q | out_rdy);
`ifdef QS_FETCH_JMP_FOLD_EN
        jmp  = (rom_rout[15:12] == 4'b0001) && (rom_rout[9:8] == 2'b00);
`else
        jmp  = 1'b0;
`endif
        nxt_pc = jmp ? rom_rout[PC_W-1:0] : pc_q + PC_W'(1);
    end

    // Next state: redirect flushes and retargets, capture loads, bare transfer empties
    always_comb begin
        pc_d   = redirect_vld ? redirect_pc : cap ? nxt_pc : pc_q;
        vld_d  = redirect_vld ? 1'b0 : cap ? 1'b1 : xfer ? 1'b0 : vld_q;
        inst_d = cap ? rom_rout : inst_q;
        opc_d  = cap ? pc_q : opc_q;
        fold_d = cap ? jmp : fold_q;
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q   <= RST_PC;
            vld_q  <= 1'b0;
            inst_q <= '0;
            opc_q  <= '0;
            fold_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            vld_q  <= vld_d;
            inst_q <= inst_d;
            opc_q  <= opc_d;
            fold_q <= fold_d;
        end
    end

    // Outputs; the ROM address shows the reset vector while reset is asserted
    always_comb begin
        rom_ra     = rst_n ? pc_q : RST_PC;
        out_vld    = vld_q;
        out_inst   = inst_q;
        out_pc     = opc_q;
        out_folded = fold_q;
    end
endmodule

// File: tb/tb_qs_fetch.sv
// tb_qs_fetch: directed checks plus a transfer-stream model of qs_fetch.
module tb_qs_fetch;
    logic        clk = 1'b0;
    logic        rst_n, fetch_en, out_rdy, redirect_vld;
    logic [7:0]  redirect_pc, rom_ra, out_pc;
    logic [15:0] rom_rout, out_inst;
    logic        out_vld, out_folded;
    logic [15:0] rom [256];
    int          checks = 0, errors = 0;
    bit          checking = 1'b0;
    logic [7:0]  exp_pc = 8'd0;
    bit          mvld = 1'b0;
    int          xq[$];
    bit          fold_on;

    always #5 clk = ~clk;

    assign rom_rout = rom[rom_ra];

    qs_fetch dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .rom_ra(rom_ra), .rom_rout(rom_rout),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_inst(out_inst), .out_pc(out_pc),
        .out_folded(out_folded), .redirect_vld(redirect_vld), .redirect_pc(redirect_pc)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_j(input logic [7:0] p);
        logic [15:0] w;
        w = rom[p];
        return fold_on && w[15:12] == 4'h1 && w[9:8] == 2'b00;
    endfunction

    function automatic logic [7:0] succ(input logic [7:0] p);
        logic [15:0] w;
        w = rom[p];
        return is_j(p) ? w[7:0] : p + 8'd1;
    endfunction

    // exp_pc is the PC the next delivered instruction must carry; mvld whether one is on offer
    always @(negedge clk) if (checking) begin
        chk("vld", out_vld, mvld);
        chk("ra", rom_ra, !rst_n ? 8'd0 : mvld ? succ(exp_pc) : exp_pc);
        if (mvld) begin
            chk("pc", out_pc, exp_pc);
            chk("inst", out_inst, rom[exp_pc]);
            chk("folded", out_folded, is_j(exp_pc));
        end
        if (!rst_n) begin
            exp_pc = 8'd0;
            mvld = 1'b0;
        end else begin
            bit xfer, cap;
            xfer = mvld & out_rdy;
            cap = fetch_en & ~redirect_vld & (~mvld | out_rdy);
            if (xfer) begin
                xq.push_back(int'(exp_pc));
                exp_pc = succ(exp_pc);
            end
            if (redirect_vld) begin
                exp_pc = redirect_pc;
                mvld = 1'b0;
            end else if (cap) mvld = 1'b1;
            else if (xfer) mvld = 1'b0;
        end
    end

    task automatic t;
        @(posedge clk);
        #2;
    endtask

    task automatic n;
        @(negedge clk);
    endtask

    initial begin
`ifdef QS_FETCH_JMP_FOLD_EN
        fold_on = 1'b1;
`else
        fold_on = 1'b0;
`endif
        for (int i = 0; i < 256; i++) rom[i] = 16'h4000 | 16'(i);
        rom[0] = 16'h1020;
        rom[5] = 16'h1120;
        rom[200] = 16'h10C8;
        rst_n = 1'b0; fetch_en = 1'b1; out_rdy = 1'b1; redirect_vld = 1'b0; redirect_pc = 8'd0;
        t; t;
        checking = 1'b1;
        n;
        chk("rst_vld", out_vld, 0); chk("rst_pc", out_pc, 0); chk("rst_inst", out_inst, 0);
        chk("rst_fold", out_folded, 0); chk("rst_ra", rom_ra, 0);
        t; rst_n = 1'b1;
        n; chk("rel_vld", out_vld, 0);
        t; n; chk("seq0_pc", out_pc, 0); chk("seq0_inst", out_inst, 16'h1020);
        chk("seq0_fold", out_folded, fold_on);
        t; n; chk("seq1_pc", out_pc, fold_on ? 32 : 1); chk("seq1_fold", out_folded, 0);
        chk("seq1_vld", out_vld, 1);
        t; n; chk("seq2_pc", out_pc, fold_on ? 33 : 2);
        t; n; chk("seq3_pc", out_pc, fold_on ? 34 : 3);
        t; redirect_vld = 1'b1; redirect_pc = 8'd33;
        t; redirect_vld = 1'b0; out_rdy = 1'b0;
        n; chk("bp_empty", out_vld, 0); chk("bp_ra33", rom_ra, 33);
        for (int i = 0; i < 3; i++) begin
            t; n;
            chk("bp_pc", out_pc, 33); chk("bp_inst", out_inst, 16'h4021); chk("bp_ra", rom_ra, 34);
        end
        t; out_rdy = 1'b1;
        n; chk("bp_last", out_pc, 33);
        t; n; chk("bp_next", out_pc, 34);
        t; out_rdy = 1'b0;
        n; chk("rf_pc35", out_pc, 35);
        t; redirect_vld = 1'b1; redirect_pc = 8'd64;
        n; chk("rf_hold", out_pc, 35);
        t; redirect_vld = 1'b0;
        n; chk("rf_flush", out_vld, 0); chk("rf_ra", rom_ra, 64);
        t; n; chk("rf_vld", out_vld, 1); chk("rf_pc64", out_pc, 64);
        t; out_rdy = 1'b1; redirect_vld = 1'b1; redirect_pc = 8'd96;
        t; redirect_vld = 1'b0;
        n; chk("sr_flush", out_vld, 0); chk("sr_ra", rom_ra, 96);
        t; n; chk("sr_pc96", out_pc, 96);
        #1; chk("sr_xfer64", xq[xq.size()-2], 64); chk("sr_xfer96", xq[xq.size()-1], 96);
        t; redirect_vld = 1'b1; redirect_pc = 8'd255;
        t; redirect_vld = 1'b0;
        t; n; chk("wr_pc255", out_pc, 255);
        t; n; chk("wr_pc0", out_pc, 0); chk("wr_ra", rom_ra, fold_on ? 32 : 1);
        t; fetch_en = 1'b0; out_rdy = 1'b0;
        t; out_rdy = 1'b1;
        t; n; chk("en_drain", out_vld, 0);
        t; fetch_en = 1'b1;
        n; chk("en_hold_vld", out_vld, 0);
        t; fetch_en = 1'b0; redirect_vld = 1'b1; redirect_pc = 8'd10;
        t; redirect_vld = 1'b0;
        n; chk("off_red_ra", rom_ra, 10);
        t; n; chk("off_idle", out_vld, 0);
        t; fetch_en = 1'b1;
        t; n; chk("off_pc10", out_pc, 10);
        t; rst_n = 1'b0; redirect_vld = 1'b1; redirect_pc = 8'd50;
        t; rst_n = 1'b1; redirect_vld = 1'b0;
        n; chk("mr_vld", out_vld, 0); chk("mr_ra", rom_ra, 0); chk("mr_pc", out_pc, 0);
        t; n; chk("mr_pc0", out_pc, 0);
        for (int i = 0; i < 400; i++) begin
            t;
            out_rdy = $urandom_range(0, 3) != 0;
            fetch_en = $urandom_range(0, 7) != 0;
            redirect_vld = $urandom_range(0, 11) == 0;
            redirect_pc = ($urandom_range(0, 3) == 0) ? 8'd200 : 8'($urandom);
        end
        redirect_vld = 1'b0;
        t; t;
        n;
        checking = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
